// File: rtl/fu_pkg.sv
// Shared types and constants for the integer execute unit and its CDB transmitter.
package fu_pkg;

   localparam int ROBEN_W  = 5;
   localparam int DATA_W   = 32;
   localparam int OPCODE_W = 12;
   localparam int RSID_W   = 5;
   localparam int ALUOP_W  = 4;

   // ALU operation encodings; codes 12..15 are unused and produce 0.
   typedef enum logic [ALUOP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10,
      ALU_LUI  = 4'd11
   } aluop_e;

   // One CDB broadcast: destination ROB entry plus result value.
   typedef struct packed {
      logic [ROBEN_W-1:0] roben;
      logic [DATA_W-1:0]  val;
   } cdb_pkt_t;

   // R-type ops carry op6 == 0 and take operand B from val2 instead of the immediate.
   function automatic logic is_rtype(input logic [OPCODE_W-1:0] opcode);
      return (opcode[11:6] == 6'd0);
   endfunction

endpackage

// File: rtl/fu_cdb_tx_result_fifo.sv
// In-order result buffer between the execute pipeline and the CDB port.
// Head entry is presented straight from storage; it reads as zero when empty.
module result_fifo
   import fu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       push,
   input  cdb_pkt_t                   push_data,
   input  logic                       pop,
   output cdb_pkt_t                   head_data,
   output logic                       head_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   cdb_pkt_t            mem_r [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_r;
   logic [PTR_W-1:0]    rd_ptr_r;
   logic [CNT_W-1:0]    count_r;
   logic                pop_s;
   logic                push_s;

   // A flush cancels both sides; a push into a full buffer is only legal alongside a pop.
   assign pop_s  = pop && !flush && (count_r != {CNT_W{1'b0}});
   assign push_s = push && !flush && ((count_r != CNT_W'(DEPTH)) || pop_s);

   // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; cleared on reset so the head never exposes stale data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   assign head_valid = (count_r != {CNT_W{1'b0}});
   assign head_data  = head_valid ? mem_r[rd_ptr_r] : '0;
   assign count      = count_r;

endmodule

// File: rtl/fu_cdb_tx.sv
// Integer execute unit: fixed-latency ALU pipeline feeding a result FIFO that
// broadcasts {ROBEN, value} on one CDB port under request/grant.
// Credits (in-flight + buffered < DEPTH) make FIFO overflow impossible.
module fu_cdb_tx
   import fu_pkg::*;
#(
   parameter int LAT   = 2,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic [RSID_W-1:0]   iss_rs_id,
   input  logic [ROBEN_W-1:0]  iss_roben,
   input  logic [OPCODE_W-1:0] iss_opcode,
   input  logic [ALUOP_W-1:0]  iss_aluop,
   input  logic [DATA_W-1:0]   iss_val1,
   input  logic [DATA_W-1:0]   iss_val2,
   input  logic [DATA_W-1:0]   iss_imm,
   output logic                fu_is_free,
   output logic                cdb_req,
   input  logic                cdb_grant,
   output logic [ROBEN_W-1:0]  cdb_roben,
   output logic [DATA_W-1:0]   cdb_val,
   output logic [3:0]          busy_cnt
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   // Whole ALU datapath; shifts use only the low five bits of B.
   function automatic logic [DATA_W-1:0] alu_exec(input logic [ALUOP_W-1:0] op,
                                                  input logic [DATA_W-1:0]  a,
                                                  input logic [DATA_W-1:0]  b);
      logic [DATA_W-1:0] r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_NOR:  r = ~(a | b);
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = DATA_W'($signed(a) >>> b[4:0]);
         ALU_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
         ALU_LUI:  r = {b[15:0], 16'd0};
         default:  r = 32'd0;
      endcase
      return r;
   endfunction

   logic              issue_s;
   logic [DATA_W-1:0] opb_s;
   logic [DATA_W-1:0] alu_res_s;
   logic [LAT-1:0]    stg_valid_r;
   cdb_pkt_t          stg_data_r [LAT];
   logic              fifo_push_s;
   logic              fifo_pop_s;
   cdb_pkt_t          head_s;
   logic              head_valid_s;
   logic [CNT_W-1:0]  fifo_cnt_s;
   logic [3:0]        infl_s;
   logic [3:0]        busy_s;

   assign issue_s   = (iss_rs_id != 5'd0) && fu_is_free;
   assign opb_s     = is_rtype(iss_opcode) ? iss_val2 : iss_imm;
   assign alu_res_s = alu_exec(iss_aluop, iss_val1, opb_s);

   // Execute pipeline: stage 0 captures the ALU result, later stages only delay it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_valid_r <= {LAT{1'b0}};
         for (int i = 0; i < LAT; i++) begin
            stg_data_r[i] <= '0;
         end
      end else if (flush) begin
         stg_valid_r <= {LAT{1'b0}};
      end else begin
         stg_valid_r[0]      <= issue_s;
         stg_data_r[0].roben <= iss_roben;
         stg_data_r[0].val   <= alu_res_s;
         for (int i = 1; i < LAT; i++) begin
            stg_valid_r[i] <= stg_valid_r[i-1];
            stg_data_r[i]  <= stg_data_r[i-1];
         end
      end
   end

   assign fifo_push_s = stg_valid_r[LAT-1] && !flush;
   assign fifo_pop_s  = cdb_req && cdb_grant && !flush;

   result_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .push       (fifo_push_s),
      .push_data  (stg_data_r[LAT-1]),
      .pop        (fifo_pop_s),
      .head_data  (head_s),
      .head_valid (head_valid_s),
      .count      (fifo_cnt_s)
   );

   // Count ops still travelling through the execute stages.
   always_comb begin
      infl_s = 4'd0;
      for (int i = 0; i < LAT; i++) begin
         infl_s = infl_s + {3'd0, stg_valid_r[i]};
      end
   end

   assign busy_s     = infl_s + 4'(fifo_cnt_s);
   assign busy_cnt   = busy_s;
   assign fu_is_free = (busy_s < 4'(DEPTH));
   assign cdb_req    = head_valid_s;
   assign cdb_roben  = head_s.roben;
   assign cdb_val    = head_s.val;

endmodule

// File: tb/tb_fu_cdb_tx.sv
// Self-checking bench for fu_cdb_tx: a scoreboard queue receives the expected
// {ROBEN, value} at issue time and a negedge monitor pops it on each granted broadcast.
module tb_fu_cdb_tx;

   localparam int LAT   = 2;
   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [4:0]  iss_rs_id;
   logic [4:0]  iss_roben;
   logic [11:0] iss_opcode;
   logic [3:0]  iss_aluop;
   logic [31:0] iss_val1;
   logic [31:0] iss_val2;
   logic [31:0] iss_imm;
   logic        fu_is_free;
   logic        cdb_req;
   logic        cdb_grant;
   logic [4:0]  cdb_roben;
   logic [31:0] cdb_val;
   logic [3:0]  busy_cnt;

   int          checks;
   int          errors;
   int          bcast_cnt;
   logic [36:0] sb_q[$];

   fu_cdb_tx #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .iss_rs_id  (iss_rs_id),
      .iss_roben  (iss_roben),
      .iss_opcode (iss_opcode),
      .iss_aluop  (iss_aluop),
      .iss_val1   (iss_val1),
      .iss_val2   (iss_val2),
      .iss_imm    (iss_imm),
      .fu_is_free (fu_is_free),
      .cdb_req    (cdb_req),
      .cdb_grant  (cdb_grant),
      .cdb_roben  (cdb_roben),
      .cdb_val    (cdb_val),
      .busy_cnt   (busy_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU, written independently as a priority chain.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic [4:0]  sh;
      sh = b[4:0];
      r  = 32'd0;
      if (op == 4'd0) r = a + b;
      else if (op == 4'd1) r = a + (~b) + 32'd1;
      else if (op == 4'd2) r = a & b;
      else if (op == 4'd3) r = a | b;
      else if (op == 4'd4) r = a ^ b;
      else if (op == 4'd5) r = ~a & ~b;
      else if (op == 4'd6) r = a << sh;
      else if (op == 4'd7) r = a >> sh;
      else if (op == 4'd8) begin
         r = a >> sh;
         for (int k = 0; k < 32; k++) if (a[31] && (k >= 32 - int'(sh))) r[k] = 1'b1;
      end
      else if (op == 4'd9) r = ((a[31] & ~b[31]) | ((a[31] == b[31]) & (a < b))) ? 32'd1 : 32'd0;
      else if (op == 4'd10) r = (a < b) ? 32'd1 : 32'd0;
      else if (op == 4'd11) r = b * 32'd65536;
      return r;
   endfunction

   // Scoreboard monitor: every accepted broadcast must match the oldest expected result.
   always @(negedge clk) begin
      if (!rst && !flush && cdb_req === 1'b1 && cdb_grant === 1'b1) begin
         logic [36:0] exp_pkt;
         bcast_cnt++;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL bcast_unexpected got roben=%0d val=%h required no broadcast", cdb_roben, cdb_val);
         end else begin
            exp_pkt = sb_q.pop_front();
            if ({cdb_roben, cdb_val} !== exp_pkt)  begin
               errors++;
               $display("FAIL bcast_data got roben=%0d val=%h required roben=%0d val=%h",
                        cdb_roben, cdb_val, exp_pkt[36:32], exp_pkt[31:0]);
            end
         end
      end
   end

   // Drive one issue for a cycle; called just after a posedge, returns just after the next one.
   task automatic issue_op(input logic [4:0] roben, input logic [11:0] opc, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic exp_acc, input logic [31:0] exp_val);
      iss_rs_id  = 5'd3;
      iss_roben  = roben;
      iss_opcode = opc;
      iss_aluop  = op;
      iss_val1   = a;
      iss_val2   = b;
      iss_imm    = imm;
      checks++;
      if (fu_is_free !== exp_acc) begin
         errors++;
         $display("FAIL issue_free roben=%0d got fu_is_free=%b required %b", roben, fu_is_free, exp_acc);
      end
      if (exp_acc) sb_q.push_back({roben, exp_val});
      @(posedge clk);
      #1;
      iss_rs_id = 5'd0;
   endtask

   // Bounded wait for all expected results to be broadcast and the unit to go idle.
   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy_cnt !== 4'd0 || sb_q.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy_cnt !== 4'd0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain got busy_cnt=%0d pending=%0d required 0 and 0", name, busy_cnt, sb_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
      iss_rs_id = 5'd0; iss_roben = 5'd0; iss_opcode = 12'd0; iss_aluop = 4'd0;
      iss_val1 = 32'd0; iss_val2 = 32'd0; iss_imm = 32'd0;
      #13;
      checks += 5;
      if (cdb_req !== 1'b0)    begin errors++; $display("FAIL reset_req got %b required 0", cdb_req); end
      if (cdb_roben !== 5'd0)  begin errors++; $display("FAIL reset_roben got %0d required 0", cdb_roben); end
      if (cdb_val !== 32'd0)   begin errors++; $display("FAIL reset_val got %h required 0", cdb_val); end
      if (busy_cnt !== 4'd0)   begin errors++; $display("FAIL reset_busy got %0d required 0", busy_cnt); end
      if (fu_is_free !== 1'b1) begin errors++; $display("FAIL reset_free got %b required 1", fu_is_free); end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_add();
      cdb_grant = 1'b1;
      issue_op(5'd7, 12'h000, 4'd0, 32'd5, 32'd10, 32'd0, 1'b1, 32'd15);
      for (int k = 0; k < LAT; k++) begin
         @(negedge clk);
         checks++;
         if (cdb_req !== 1'b0) begin errors++; $display("FAIL add_latency stage %0d got req=%b required 0", k, cdb_req); end
      end
      @(negedge clk);
      checks += 3;
      if (cdb_req !== 1'b1)   begin errors++; $display("FAIL add_req got %b required 1", cdb_req); end
      if (cdb_roben !== 5'd7) begin errors++; $display("FAIL add_roben got %0d required 7", cdb_roben); end
      if (cdb_val !== 32'd15) begin errors++; $display("FAIL add_val got %h required 0000000f", cdb_val); end
      @(negedge clk);
      checks += 2;
      if (busy_cnt !== 4'd0) begin errors++; $display("FAIL add_busy got %0d required 0", busy_cnt); end
      if (cdb_req !== 1'b0)  begin errors++; $display("FAIL add_req_drop got %b required 0", cdb_req); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_imm_alu();
      logic [31:0] a;
      logic [31:0] b;
      cdb_grant = 1'b1;
      issue_op(5'd8, 12'h200, 4'd0, 32'hFFFF_FFFF, 32'd9, 32'd2, 1'b1, 32'h0000_0001);
      issue_op(5'd9, 12'h200, 4'd8, 32'h8000_0000, 32'd9, 32'd4, 1'b1, 32'hF800_0000);
      for (int op = 1; op < 16; op++) begin
         a = $urandom();
         b = (op % 3 == 0) ? a : $urandom();
         issue_op(5'(op + 10), 12'h03F, 4'(op), a, b, ~b, 1'b1, ref_alu(4'(op), a, b));
      end
      issue_op(5'd31, 12'h040, 4'd11, 32'd0, 32'h1234_5678, 32'h0000_ABCD, 1'b1, 32'hABCD_0000);
      wait_idle("imm_alu");
   endtask

   task automatic test_back_to_back();
      cdb_grant = 1'b0;
      for (int r = 1; r <= 5; r++) begin
         issue_op(5'(r), 12'h000, 4'd3, 32'(r), 32'h100, 32'd0, (r <= DEPTH), 32'(r) | 32'h100);
      end
      checks++;
      if (busy_cnt !== 4'd4) begin errors++; $display("FAIL bp_busy got %0d required 4", busy_cnt); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks += 3;
         if (cdb_req !== 1'b1)   begin errors++; $display("FAIL bp_hold_req got %b required 1", cdb_req); end
         if (cdb_roben !== 5'd1) begin errors++; $display("FAIL bp_hold_roben got %0d required 1", cdb_roben); end
         if (fu_is_free !== 1'b0) begin errors++; $display("FAIL bp_hold_free got %b required 0", fu_is_free); end
      end
      @(posedge clk);
      #1;
      cdb_grant = 1'b1;
      wait_idle("back_pressure");
      cdb_grant = 1'b0;
   endtask

   task automatic test_push_pop_full();
      cdb_grant = 1'b0;
      for (int r = 10; r <= 13; r++) begin
         issue_op(5'(r), 12'h000, 4'd4, 32'(r), 32'hA5A5_0000, 32'd0, 1'b1, 32'(r) ^ 32'hA5A5_0000);
      end
      repeat (LAT - 1) @(posedge clk);
      #1;
      cdb_grant = 1'b1;
      @(negedge clk);
      checks += 2;
      if (busy_cnt !== 4'd4)   begin errors++; $display("FAIL pp_busy_before got %0d required 4", busy_cnt); end
      if (cdb_roben !== 5'd10) begin errors++; $display("FAIL pp_head_before got %0d required 10", cdb_roben); end
      @(posedge clk);
      #1;
      cdb_grant = 1'b0;
      @(negedge clk);
      checks += 3;
      if (busy_cnt !== 4'd3)   begin errors++; $display("FAIL pp_busy_after got %0d required 3", busy_cnt); end
      if (cdb_roben !== 5'd11) begin errors++; $display("FAIL pp_head_after got %0d required 11", cdb_roben); end
      if (cdb_req !== 1'b1)    begin errors++; $display("FAIL pp_req_after got %b required 1", cdb_req); end
      @(posedge clk);
      #1;
      issue_op(5'd14, 12'h000, 4'd1, 32'd100, 32'd1, 32'd0, 1'b1, 32'd99);
      cdb_grant = 1'b1;
      wait_idle("push_pop");
      cdb_grant = 1'b0;
   endtask

   task automatic test_flush();
      int bc0;
      cdb_grant = 1'b0;
      issue_op(5'd1, 12'h000, 4'd0, 32'd1, 32'd1, 32'd0, 1'b1, 32'd2);
      issue_op(5'd2, 12'h000, 4'd0, 32'd2, 32'd2, 32'd0, 1'b1, 32'd4);
      repeat (LAT) @(posedge clk);
      #1;
      issue_op(5'd3, 12'h000, 4'd0, 32'd3, 32'd3, 32'd0, 1'b1, 32'd6);
      issue_op(5'd4, 12'h000, 4'd0, 32'd4, 32'd4, 32'd0, 1'b1, 32'd8);
      checks++;
      if (busy_cnt !== 4'd4) begin errors++; $display("FAIL flush_pre_busy got %0d required 4", busy_cnt); end
      flush = 1'b1; cdb_grant = 1'b1;
      iss_rs_id = 5'd9; iss_roben = 5'd20;
      @(posedge clk);
      #1;
      flush = 1'b0; iss_rs_id = 5'd0;
      sb_q.delete();
      bc0 = bcast_cnt;
      @(negedge clk);
      checks += 4;
      if (cdb_req !== 1'b0)    begin errors++; $display("FAIL flush_req got %b required 0", cdb_req); end
      if (busy_cnt !== 4'd0)   begin errors++; $display("FAIL flush_busy got %0d required 0", busy_cnt); end
      if (fu_is_free !== 1'b1) begin errors++; $display("FAIL flush_free got %b required 1", fu_is_free); end
      if (cdb_roben !== 5'd0)  begin errors++; $display("FAIL flush_roben got %0d required 0", cdb_roben); end
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bcast_cnt != bc0) begin errors++; $display("FAIL flush_no_bcast got %0d broadcasts required 0", bcast_cnt - bc0); end
      cdb_grant = 1'b0;
   endtask

   task automatic test_async_reset();
      int bc0;
      cdb_grant = 1'b0;
      issue_op(5'd21, 12'h000, 4'd4, 32'hFFFF_0000, 32'h00FF_00FF, 32'd0, 1'b1, 32'hFF00_00FF);
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if (cdb_req !== 1'b1) begin errors++; $display("FAIL arst_pre_req got %b required 1", cdb_req); end
      issue_op(5'd22, 12'h000, 4'd0, 32'd7, 32'd7, 32'd0, 1'b1, 32'd14);
      #1;
      rst = 1'b1;
      #1;
      checks += 5;
      if (cdb_req !== 1'b0)    begin errors++; $display("FAIL arst_req got %b required 0", cdb_req); end
      if (cdb_roben !== 5'd0)  begin errors++; $display("FAIL arst_roben got %0d required 0", cdb_roben); end
      if (cdb_val !== 32'd0)   begin errors++; $display("FAIL arst_val got %h required 0", cdb_val); end
      if (busy_cnt !== 4'd0)   begin errors++; $display("FAIL arst_busy got %0d required 0", busy_cnt); end
      if (fu_is_free !== 1'b1) begin errors++; $display("FAIL arst_free got %b required 1", fu_is_free); end
      #1;
      rst = 1'b0;
      sb_q.delete();
      bc0 = bcast_cnt;
      cdb_grant = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checks += 2;
      if (bcast_cnt != bc0)  begin errors++; $display("FAIL arst_no_bcast got %0d broadcasts required 0", bcast_cnt - bc0); end
      if (busy_cnt !== 4'd0) begin errors++; $display("FAIL arst_post_busy got %0d required 0", busy_cnt); end
      cdb_grant = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      bcast_cnt = 0;
      test_reset();
      test_single_add();
      test_imm_alu();
      test_back_to_back();
      test_push_pop_full();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
